// File: rtl/sp_types_pkg.sv
// sp_types_pkg: default sizes, payload structs and a saturating-increment helper
// for the scratchpad bank. Items:
//   SP_* localparams  default geometry used as the bank's parameter defaults
//   sp_wr_req_t       write request at default widths
//   sp_rd_req_t       read request at default widths
//   dramFIFO_t        DRAM writeback entry {addr, mat, row, data}
//   gemmFIFO_t        GEMM operand entry {matt, mat, row, data}
//   sat_inc           32-bit increment that sticks at all-ones
package sp_types_pkg;
    localparam int SP_NUM_MATS = 4;
    localparam int SP_ROWS     = 4;
    localparam int SP_ROW_W    = 64;
    localparam int SP_ADDR_W   = 32;
    localparam int SP_MATT_W   = 2;
    localparam int SP_MS_W     = $clog2(SP_NUM_MATS);
    localparam int SP_RS_W     = $clog2(SP_ROWS);

    typedef struct packed {
        logic                gemm;
        logic [SP_MS_W-1:0]  mat;
        logic [SP_RS_W-1:0]  row;
        logic [SP_ROW_W-1:0] data;
    } sp_wr_req_t;

    typedef struct packed {
        logic [SP_MATT_W-1:0] matt;
        logic [SP_ADDR_W-1:0] addr;
        logic [SP_MS_W-1:0]   mat;
        logic [SP_RS_W-1:0]   row;
    } sp_rd_req_t;

    typedef struct packed {
        logic [SP_ADDR_W-1:0] addr;
        logic [SP_MS_W-1:0]   mat;
        logic [SP_RS_W-1:0]   row;
        logic [SP_ROW_W-1:0]  data;
    } dramFIFO_t;

    typedef struct packed {
        logic [SP_MATT_W-1:0] matt;
        logic [SP_MS_W-1:0]   mat;
        logic [SP_RS_W-1:0]   row;
        logic [SP_ROW_W-1:0]  data;
    } gemmFIFO_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        return (en && v != '1) ? v + 32'd1 : v;
    endfunction
endpackage

// File: rtl/socetlib_fifo.sv
// socetlib_fifo: synchronous FIFO, head visible on rdata one cycle after push.
// Ports:
//   CLK, nRST     clock, asynchronous active-low reset (empties the FIFO)
//   wen, wdata    push request and data (ignored when full)
//   ren           pop request (ignored when empty)
//   full, empty   occupancy flags
//   rdata         current head entry (don't-care when empty)
// DEPTH must be a power of two so the pointers wrap naturally.
module socetlib_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             wen,
    input  logic             ren,
    input  logic [WIDTH-1:0] wdata,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] rdata
);
    localparam int PW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [PW:0] cnt_q, cnt_d;
    logic push, pop;
    assign full  = cnt_q == (PW+1)'(DEPTH);
    assign empty = cnt_q == '0;
    assign push  = wen & ~full;
    assign pop   = ren & ~empty;
    assign rdata = mem_q[rptr_q];
    always_comb begin
        wptr_d = push ? wptr_q + PW'(1) : wptr_q;
        rptr_d = pop ? rptr_q + PW'(1) : rptr_q;
        cnt_d  = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
    end
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end
    always_ff @(posedge CLK) begin
        if (push) mem_q[wptr_q] <= wdata;
    end
endmodule

// File: rtl/sp_row_tracker.sv
// sp_row_tracker: per-matrix row-written masks, sticky mat_full and completion pulses.
// Ports:
//   CLK, nRST                        clock, asynchronous active-low reset
//   wr_valid, wr_mat, wr_row, wr_gemm  observed write
//   mat_clr                          per-matrix clear of mask and mat_full
//   load_done, gemm_done, done_mat   one-cycle completion pulse and its matrix
//   mat_full                         sticky per-matrix all-rows-written flag
module sp_row_tracker #(
    parameter int NUM_MATS = 4,
    parameter int ROWS     = 4,
    localparam int MS_W = $clog2(NUM_MATS),
    localparam int RS_W = $clog2(ROWS)
) (
    input  logic                CLK,
    input  logic                nRST,
    input  logic                wr_valid,
    input  logic [MS_W-1:0]     wr_mat,
    input  logic [RS_W-1:0]     wr_row,
    input  logic                wr_gemm,
    input  logic [NUM_MATS-1:0] mat_clr,
    output logic                load_done,
    output logic                gemm_done,
    output logic [MS_W-1:0]     done_mat,
    output logic [NUM_MATS-1:0] mat_full
);
    logic [ROWS-1:0] mask_q [NUM_MATS];
    logic [ROWS-1:0] mask_d [NUM_MATS];
    logic [NUM_MATS-1:0] full_q, full_d;
    logic load_done_q, load_done_d, gemm_done_q, gemm_done_d;
    logic [MS_W-1:0] done_mat_q, done_mat_d;
    logic complete;
    // Clears land before the write so a same-cycle write to a cleared matrix
    // starts a fresh mask. A completing write resets its mask directly, so the
    // all-ones state is never held.
    always_comb begin
        mask_d = mask_q;
        full_d = full_q;
        complete = 1'b0;
        for (int m = 0; m < NUM_MATS; m++) begin
            if (mat_clr[m]) begin
                mask_d[m] = '0;
                full_d[m] = 1'b0;
            end
        end
        if (wr_valid) begin
            mask_d[wr_mat][wr_row] = 1'b1;
            complete = &mask_d[wr_mat];
            if (complete) begin
                mask_d[wr_mat] = '0;
                full_d[wr_mat] = 1'b1;
            end
        end
        load_done_d = complete & ~wr_gemm;
        gemm_done_d = complete & wr_gemm;
        done_mat_d  = complete ? wr_mat : done_mat_q;
    end
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            mask_q      <= '{default: '0};
            full_q      <= '0;
            load_done_q <= 1'b0;
            gemm_done_q <= 1'b0;
            done_mat_q  <= '0;
        end else begin
            mask_q      <= mask_d;
            full_q      <= full_d;
            load_done_q <= load_done_d;
            gemm_done_q <= gemm_done_d;
            done_mat_q  <= done_mat_d;
        end
    end
    assign load_done = load_done_q;
    assign gemm_done = gemm_done_q;
    assign done_mat  = done_mat_q;
    assign mat_full  = full_q;
endmodule

// File: rtl/sp_bank_param.sv
// sp_bank_param: parametrised scratchpad bank with DRAM-writeback and GEMM-operand
// read queues, row-completion tracking and same-cycle write-to-read forwarding.
// Ports:
//   CLK, nRST                         clock, asynchronous active-low reset
//   wr_*                              row write (always accepted)
//   rd_valid/rd_ready, rd_*           read request; rd_matt==0 -> DRAM queue
//   dram_ren/empty/rdata              DRAM queue pop side {addr, mat, row, data}
//   gemm_ren/empty/rdata              GEMM queue pop side {matt, mat, row, data}
//   load_done, gemm_done, done_mat    matrix-complete pulse
//   mat_full, mat_clr                 sticky complete flags and their clear
//   perf_*                            counters, present only with SP_BANK_PERF_EN
module sp_bank_param
    import sp_types_pkg::*;
#(
    parameter int NUM_MATS   = SP_NUM_MATS,
    parameter int ROWS       = SP_ROWS,
    parameter int ROW_W      = SP_ROW_W,
    parameter int ADDR_W     = SP_ADDR_W,
    parameter int MATT_W     = SP_MATT_W,
    parameter int DRAM_DEPTH = 4,
    parameter int GEMM_DEPTH = 8,
    localparam int MS_W   = $clog2(NUM_MATS),
    localparam int RS_W   = $clog2(ROWS),
    localparam int DRAM_W = ADDR_W + MS_W + RS_W + ROW_W,
    localparam int GEMM_W = MATT_W + MS_W + RS_W + ROW_W
) (
    input  logic                CLK,
    input  logic                nRST,
    input  logic                wr_valid,
    input  logic [MS_W-1:0]     wr_mat,
    input  logic [RS_W-1:0]     wr_row,
    input  logic [ROW_W-1:0]    wr_data,
    input  logic                wr_gemm,
    input  logic                rd_valid,
    output logic                rd_ready,
    input  logic [MS_W-1:0]     rd_mat,
    input  logic [RS_W-1:0]     rd_row,
    input  logic [MATT_W-1:0]   rd_matt,
    input  logic [ADDR_W-1:0]   rd_addr,
    input  logic                dram_ren,
    output logic                dram_empty,
    output logic [DRAM_W-1:0]   dram_rdata,
    input  logic                gemm_ren,
    output logic                gemm_empty,
    output logic [GEMM_W-1:0]   gemm_rdata,
    output logic                load_done,
    output logic                gemm_done,
    output logic [MS_W-1:0]     done_mat,
    output logic [NUM_MATS-1:0] mat_full,
`ifdef SP_BANK_PERF_EN
    output logic [31:0]         perf_rd_stall,
    output logic [31:0]         perf_dram_rd,
    output logic [31:0]         perf_gemm_rd,
    output logic [31:0]         perf_fwd,
`endif
    input  logic [NUM_MATS-1:0] mat_clr
);
    logic [ROW_W-1:0] mem_q [NUM_MATS][ROWS];
    logic [ROW_W-1:0] mem_d [NUM_MATS][ROWS];
    logic [ROW_W-1:0] rd_data;
    logic rd_dram, fwd, dram_full, gemm_full, dram_wen, gemm_wen;
    always_comb begin
        mem_d = mem_q;
        if (wr_valid) mem_d[wr_mat][wr_row] = wr_data;
    end
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int m = 0; m < NUM_MATS; m++)
                for (int r = 0; r < ROWS; r++)
                    mem_q[m][r] <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end
    // A read colliding with a write to the same row takes the incoming data.
    assign fwd      = wr_valid && (wr_mat == rd_mat) && (wr_row == rd_row);
    assign rd_data  = fwd ? wr_data : mem_q[rd_mat][rd_row];
    assign rd_dram  = rd_matt == '0;
    // Uses the current full flag, so a pop in the same cycle does not free a slot.
    assign rd_ready = nRST & rd_valid & ~(rd_dram ? dram_full : gemm_full);
    assign dram_wen = rd_ready & rd_dram;
    assign gemm_wen = rd_ready & ~rd_dram;

    socetlib_fifo #(.WIDTH(DRAM_W), .DEPTH(DRAM_DEPTH)) u_dram_fifo (
        .CLK   (CLK),
        .nRST  (nRST),
        .wen   (dram_wen),
        .ren   (dram_ren),
        .wdata ({rd_addr, rd_mat, rd_row, rd_data}),
        .full  (dram_full),
        .empty (dram_empty),
        .rdata (dram_rdata)
    );

    socetlib_fifo #(.WIDTH(GEMM_W), .DEPTH(GEMM_DEPTH)) u_gemm_fifo (
        .CLK   (CLK),
        .nRST  (nRST),
        .wen   (gemm_wen),
        .ren   (gemm_ren),
        .wdata ({rd_matt, rd_mat, rd_row, rd_data}),
        .full  (gemm_full),
        .empty (gemm_empty),
        .rdata (gemm_rdata)
    );

    sp_row_tracker #(.NUM_MATS(NUM_MATS), .ROWS(ROWS)) u_tracker (
        .CLK       (CLK),
        .nRST      (nRST),
        .wr_valid  (wr_valid),
        .wr_mat    (wr_mat),
        .wr_row    (wr_row),
        .wr_gemm   (wr_gemm),
        .mat_clr   (mat_clr),
        .load_done (load_done),
        .gemm_done (gemm_done),
        .done_mat  (done_mat),
        .mat_full  (mat_full)
    );

`ifdef SP_BANK_PERF_EN
    logic [31:0] perf_rd_stall_q, perf_rd_stall_d, perf_dram_rd_q, perf_dram_rd_d;
    logic [31:0] perf_gemm_rd_q, perf_gemm_rd_d, perf_fwd_q, perf_fwd_d;
    always_comb begin
        perf_rd_stall_d = sat_inc(perf_rd_stall_q, rd_valid & ~rd_ready);
        perf_dram_rd_d  = sat_inc(perf_dram_rd_q, dram_wen);
        perf_gemm_rd_d  = sat_inc(perf_gemm_rd_q, gemm_wen);
        perf_fwd_d      = sat_inc(perf_fwd_q, rd_ready & fwd);
    end
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            perf_rd_stall_q <= '0;
            perf_dram_rd_q  <= '0;
            perf_gemm_rd_q  <= '0;
            perf_fwd_q      <= '0;
        end else begin
            perf_rd_stall_q <= perf_rd_stall_d;
            perf_dram_rd_q  <= perf_dram_rd_d;
            perf_gemm_rd_q  <= perf_gemm_rd_d;
            perf_fwd_q      <= perf_fwd_d;
        end
    end
    assign perf_rd_stall = perf_rd_stall_q;
    assign perf_dram_rd  = perf_dram_rd_q;
    assign perf_gemm_rd  = perf_gemm_rd_q;
    assign perf_fwd      = perf_fwd_q;
`endif
endmodule

// File: tb/tb_sp_bank_param.sv
// tb_sp_bank_param: scoreboard bench for sp_bank_param with directed scenarios and random traffic.
module tb_sp_bank_param;
    import sp_types_pkg::*;
    localparam int NM = SP_NUM_MATS;
    localparam int NR = SP_ROWS;
    localparam int DD = 4;
    localparam int GD = 8;

    logic CLK, nRST;
    logic wr_valid, wr_gemm, rd_valid, rd_ready;
    logic [SP_MS_W-1:0] wr_mat, rd_mat, done_mat;
    logic [SP_RS_W-1:0] wr_row, rd_row;
    logic [SP_ROW_W-1:0] wr_data;
    logic [SP_MATT_W-1:0] rd_matt;
    logic [SP_ADDR_W-1:0] rd_addr;
    logic dram_ren, dram_empty, gemm_ren, gemm_empty, load_done, gemm_done;
    dramFIFO_t dram_rdata;
    gemmFIFO_t gemm_rdata;
    logic [NM-1:0] mat_full, mat_clr;

    sp_bank_param dut (
        .CLK(CLK), .nRST(nRST),
        .wr_valid(wr_valid), .wr_mat(wr_mat), .wr_row(wr_row), .wr_data(wr_data), .wr_gemm(wr_gemm),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_mat(rd_mat), .rd_row(rd_row),
        .rd_matt(rd_matt), .rd_addr(rd_addr),
        .dram_ren(dram_ren), .dram_empty(dram_empty), .dram_rdata(dram_rdata),
        .gemm_ren(gemm_ren), .gemm_empty(gemm_empty), .gemm_rdata(gemm_rdata),
        .load_done(load_done), .gemm_done(gemm_done), .done_mat(done_mat),
        .mat_full(mat_full), .mat_clr(mat_clr)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int failures = 0;

    // Reference model: row contents, set of rows seen per matrix, queues of expected output.
    logic [SP_ROW_W-1:0] mem_m [NM][NR];
    bit seen [NM][NR];
    int nseen [NM];
    logic [NM-1:0] exp_full;
    logic exp_ready;
    dramFIFO_t dq [$];
    gemmFIFO_t gq [$];
    logic [SP_MS_W:0] doneq [$];
    logic [SP_MS_W:0] ev;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < NM; m++) begin
            nseen[m] = 0;
            for (int r = 0; r < NR; r++) begin
                mem_m[m][r] = '0;
                seen[m][r] = 0;
            end
        end
        exp_full = '0;
        exp_ready = 1'b0;
        dq.delete();
        gq.delete();
        doneq.delete();
    endtask

    // Called just after an active edge with this cycle's inputs already driven.
    task automatic tick();
        dramFIFO_t di;
        gemmFIFO_t gi;
        logic [SP_ROW_W-1:0] rdat;
        logic acc, is_dram;
        is_dram = rd_matt == '0;
        exp_ready = rd_valid && (is_dram ? dq.size() < DD : gq.size() < GD);
        acc = exp_ready;
        rdat = (wr_valid && wr_mat == rd_mat && wr_row == rd_row) ? wr_data : mem_m[rd_mat][rd_row];
        di = '{addr: rd_addr, mat: rd_mat, row: rd_row, data: rdat};
        gi = '{matt: rd_matt, mat: rd_mat, row: rd_row, data: rdat};
        @(posedge CLK);
        #1;
        for (int m = 0; m < NM; m++) begin
            if (mat_clr[m]) begin
                exp_full[m] = 1'b0;
                nseen[m] = 0;
                for (int r = 0; r < NR; r++) seen[m][r] = 0;
            end
        end
        if (wr_valid) begin
            mem_m[wr_mat][wr_row] = wr_data;
            if (!seen[wr_mat][wr_row]) begin
                seen[wr_mat][wr_row] = 1;
                nseen[wr_mat]++;
            end
            if (nseen[wr_mat] == NR) begin
                nseen[wr_mat] = 0;
                for (int r = 0; r < NR; r++) seen[wr_mat][r] = 0;
                exp_full[wr_mat] = 1'b1;
                doneq.push_back({wr_gemm, wr_mat});
            end
        end
        if (acc) begin
            if (is_dram) dq.push_back(di);
            else gq.push_back(gi);
        end
    endtask

    // Monitor: compares whatever the DUT presents against the scoreboard.
    always @(negedge CLK) begin
        if (nRST) begin
            chk("rd_ready", 128'(rd_ready), 128'(exp_ready));
            chk("dram_empty", 128'(dram_empty), 128'(dq.size() == 0));
            chk("gemm_empty", 128'(gemm_empty), 128'(gq.size() == 0));
            if (dram_ren && dq.size() > 0) chk("dram_rdata", 128'(dram_rdata), 128'(dq.pop_front()));
            if (gemm_ren && gq.size() > 0) chk("gemm_rdata", 128'(gemm_rdata), 128'(gq.pop_front()));
            if (doneq.size() > 0) begin
                ev = doneq.pop_front();
                chk("load_done", 128'(load_done), 128'(!ev[SP_MS_W]));
                chk("gemm_done", 128'(gemm_done), 128'(ev[SP_MS_W]));
                chk("done_mat", 128'(done_mat), 128'(ev[SP_MS_W-1:0]));
            end else begin
                chk("done_idle", 128'({load_done, gemm_done}), 128'(0));
            end
            chk("mat_full", 128'(mat_full), 128'(exp_full));
        end
    end

    task automatic idle_inputs();
        wr_valid = 0; wr_gemm = 0; wr_mat = '0; wr_row = '0; wr_data = '0;
        rd_valid = 0; rd_mat = '0; rd_row = '0; rd_matt = '0; rd_addr = '0;
        dram_ren = 0; gemm_ren = 0; mat_clr = '0;
    endtask

    task automatic drain();
        wr_valid = 0; mat_clr = '0; dram_ren = 1; gemm_ren = 1;
        for (int i = 0; i < 40; i++) begin
            if (!(rd_valid && !exp_ready)) rd_valid = 0;
            if (!rd_valid && dq.size() == 0 && gq.size() == 0) break;
            tick();
        end
        dram_ren = 0; gemm_ren = 0;
    endtask

    task automatic rand_run(input int n);
        for (int i = 0; i < n; i++) begin
            wr_valid = $urandom_range(0, 1) == 1;
            wr_gemm  = $urandom_range(0, 1) == 1;
            wr_mat   = SP_MS_W'($urandom);
            wr_row   = SP_RS_W'($urandom);
            wr_data  = {$urandom, $urandom};
            if (!(rd_valid && !exp_ready)) begin
                rd_valid = $urandom_range(0, 4) < 3;
                rd_mat   = SP_MS_W'($urandom);
                rd_row   = SP_RS_W'($urandom);
                rd_matt  = ($urandom_range(0, 1) == 1) ? '0 : SP_MATT_W'($urandom_range(1, 3));
                rd_addr  = $urandom;
            end
            dram_ren = $urandom_range(0, 2) == 0;
            gemm_ren = $urandom_range(0, 2) == 0;
            mat_clr  = ($urandom_range(0, 19) == 0) ? NM'($urandom) : '0;
            tick();
        end
    endtask

    int seq [5] = '{3, 1, 1, 0, 2};

    initial begin
        nRST = 0;
        idle_inputs();
        model_reset();
        rd_valid = 1;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_dram_empty", 128'(dram_empty), 128'(1));
        chk("rst_gemm_empty", 128'(gemm_empty), 128'(1));
        chk("rst_mat_full", 128'(mat_full), 128'(0));
        chk("rst_load_done", 128'(load_done), 128'(0));
        chk("rst_gemm_done", 128'(gemm_done), 128'(0));
        chk("rst_done_mat", 128'(done_mat), 128'(0));
        chk("rst_rd_ready", 128'(rd_ready), 128'(0));
        rd_valid = 0;
        @(posedge CLK);
        #1;
        nRST = 1;

        // Load path: mat 2 rows 0..3 from DRAM.
        wr_valid = 1; wr_gemm = 0; wr_mat = 2;
        for (int r = 0; r < NR; r++) begin
            wr_row = SP_RS_W'(r);
            wr_data = {$urandom, $urandom};
            tick();
            chk("load_pulse", 128'(load_done), 128'(r == NR - 1));
        end
        wr_valid = 0;
        chk("load_mat", 128'(done_mat), 128'(2));
        chk("load_full", 128'(mat_full), 128'(4'b0100));

        // Out-of-order GEMM rows with a repeated row.
        wr_valid = 1; wr_gemm = 1; wr_mat = 1;
        for (int i = 0; i < 5; i++) begin
            wr_row = SP_RS_W'(seq[i]);
            wr_data = {$urandom, $urandom};
            tick();
            chk("ooo_pulse", 128'(gemm_done), 128'(i == 4));
        end
        wr_valid = 0;
        chk("ooo_mat", 128'(done_mat), 128'(1));
        chk("ooo_full", 128'(mat_full), 128'(4'b0110));

        // Clear racing the completing write on mat 3.
        wr_valid = 1; wr_gemm = 0; wr_mat = 3;
        for (int r = 1; r < NR; r++) begin
            wr_row = SP_RS_W'(r);
            tick();
        end
        wr_row = 0; mat_clr = 4'b1000;
        tick();
        mat_clr = '0;
        chk("clr_full", 128'(mat_full[3]), 128'(0));
        chk("clr_nopulse", 128'(load_done), 128'(0));
        for (int r = 1; r < NR; r++) begin
            wr_row = SP_RS_W'(r);
            tick();
            chk("clr_refill", 128'(load_done), 128'(r == NR - 1));
        end
        wr_valid = 0;
        chk("clr_mat", 128'(done_mat), 128'(3));

        // Forwarding: stale 0xAAAA replaced by same-cycle 0x5555.
        wr_valid = 1; wr_mat = 0; wr_row = 1; wr_data = 64'hAAAA;
        tick();
        wr_data = 64'h5555;
        rd_valid = 1; rd_mat = 0; rd_row = 1; rd_matt = 1;
        tick();
        wr_valid = 0; rd_valid = 0;
        chk("fwd_data", 128'(gemm_rdata.data), 128'(64'h5555));
        chk("fwd_nonempty", 128'(gemm_empty), 128'(0));
        drain();

        // Backpressure: 5 DRAM reads into a 4-deep queue.
        for (int i = 0; i < 5; i++) begin
            rd_valid = 1; rd_matt = 0; rd_mat = SP_MS_W'(i); rd_row = SP_RS_W'(i);
            rd_addr = 32'h1000 + i;
            #1;
            chk("bp_ready", 128'(rd_ready), 128'(i < DD));
            tick();
        end
        dram_ren = 1;
        #1;
        chk("bp_pop_full", 128'(rd_ready), 128'(0));
        tick();
        dram_ren = 0;
        #1;
        chk("bp_accept", 128'(rd_ready), 128'(1));
        tick();
        rd_valid = 0;
        chk("bp_head", 128'(dram_rdata.addr), 128'(32'h1001));
        drain();

        rand_run(600);
        drain();

        // Reset mid-stream: three GEMM entries queued and a load pulse showing.
        mat_clr = '1;
        tick();
        mat_clr = '0;
        wr_valid = 1; wr_gemm = 0; wr_mat = 0;
        for (int r = 0; r < NR; r++) begin
            wr_row = SP_RS_W'(r);
            wr_data = {$urandom, $urandom};
            rd_valid = r < 3; rd_matt = 2; rd_mat = 1; rd_row = SP_RS_W'(r);
            tick();
        end
        wr_valid = 0; rd_valid = 0;
        chk("pre_rst_pulse", 128'(load_done), 128'(1));
        chk("pre_rst_gemm", 128'(gemm_empty), 128'(0));
        nRST = 0;
        #1;
        chk("mid_rst_gemm_empty", 128'(gemm_empty), 128'(1));
        chk("mid_rst_full", 128'(mat_full), 128'(0));
        chk("mid_rst_pulse", 128'({load_done, gemm_done}), 128'(0));
        model_reset();
        @(posedge CLK);
        #1;
        nRST = 1;

        rand_run(300);
        drain();
        chk("end_dram_empty", 128'(dram_empty), 128'(1));
        chk("end_gemm_empty", 128'(gemm_empty), 128'(1));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
